hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and stall scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It sequences the pipeline registers through three cases:
- a one-cycle load-use bubble;
- data-memory wait stalls with a timeout;
- control-flow redirect flushes.

It complements the EX-stage operand forwarding logic by covering the hazards that forwarding cannot resolve. Its outputs drive the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register.

Parameters:
MEM_TIMEOUT, 16, max MEM_WAIT cycles before o_mem_err pulses and the access is abandoned (min 2)
CNT_W, 32, width of performance counters (only with PERF_CNT_EN)

Ports:
i_clk  input  1  core clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_instr_ID  input  32  instruction in ID
i_instr_EX  input  32  instruction in EX
i_rd_wren_EX  input  1  EX instruction writes rd
i_redirect_EX  input  1  EX resolved taken branch/jump (PC redirect)
i_dmem_req_MEM  input  1  MEM stage has a valid load/store access
i_dmem_ready  input  1  data memory completes access this cycle
o_pc_en  output  1  PC register load enable
o_ifid_en  output  1  IF/ID register enable
o_ifid_flush  output  1  IF/ID register cleared to NOP (0x00000013)
o_idex_en  output  1  ID/EX register enable
o_idex_flush  output  1  ID/EX register cleared to NOP
o_exmem_en  output  1  EX/MEM register enable
o_memwb_bubble  output  1  MEM/WB loads NOP instead of MEM result
o_mem_err  output  1  one-cycle pulse on MEM_WAIT timeout
o_state  output  2  FSM state, for debug

Behaviour:
- Decode. Fields are rs1 = [19:15], rs2 = [24:20], rd = [11:7], op = [6:2].
  - Load in EX: op_EX == 5'b00000.
  - rs1 used by ID: op_ID not in {01101 LUI, 00101 AUIPC, 11011 JAL}.
  - rs2 used by ID: op_ID in {01100 R, 01000 S, 11000 B}.
- Load-use condition: load_EX & i_rd_wren_EX & rd_EX != 0 & ((rs1 used & rs1_ID == rd_EX) | (rs2 used & rs2_ID == rd_EX)).
- Memory-wait condition: i_dmem_req_MEM & ~i_dmem_ready.
- FSM states (o_state): RUN = 2'd0, LU_BUBBLE = 2'd1, MEM_WAIT = 2'd2; 2'd3 is illegal and recovers to RUN.
- Reset: state = RUN, wait counter = 0. Outputs during reset:
  - o_pc_en = o_ifid_en = o_idex_en = o_exmem_en = 1;
  - o_ifid_flush = o_idex_flush = o_memwb_bubble = o_mem_err = 0.
- Reset mid-operation aborts any stall immediately, because reset is asynchronous.
- Output default (RUN, no condition active): all enables = 1, all flushes/bubbles = 0.
- Priority within a cycle: memory wait > redirect > load-use.
- RUN, memory-wait condition true:
  - all enables = 0 and o_memwb_bubble = 1 in the same cycle (combinational, zero latency);
  - next state = MEM_WAIT; counter = 1.
  - Redirect and load-use are suppressed. EX is frozen, so they re-evaluate on release.
- RUN, i_redirect_EX (no memory wait): o_ifid_flush = o_idex_flush = 1, PC loads the target; stay in RUN.
  - A redirect coinciding with load-use resolves as redirect only, because the ID instruction is squashed.
- RUN, load-use (no memory wait, no redirect):
  - o_pc_en = o_ifid_en = 0, o_idex_flush = 1;
  - next state = LU_BUBBLE.
- LU_BUBBLE: all enables = 1; next state = RUN. It lasts exactly one cycle even if the condition still appears true.
  - The load is now in MEM and the forwarding path covers the dependency.
  - A memory wait arriving in this cycle takes the MEM_WAIT path above instead.
- MEM_WAIT: all enables = 0, o_memwb_bubble = 1, counter increments.
  - i_dmem_ready = 1: the access completes. This cycle has normal RUN outputs (MEM/WB captures the result). Next state = RUN, counter = 0.
  - Counter == MEM_TIMEOUT and still not ready: o_mem_err = 1 for one cycle. Release as for ready, but o_memwb_bubble stays 1, so the access is dropped. Next state = RUN.
  - i_dmem_req_MEM dropping while waiting counts as completion.
- Counter width: $clog2(MEM_TIMEOUT+1). It never wraps, because it saturates at the timeout.

Optional Feature:
HAZARD_PERF_CNT_EN. When defined, three extra outputs are added, each CNT_W bits wide:
- o_cnt_lu: load-use bubbles;
- o_cnt_memwait: MEM_WAIT cycles;
- o_cnt_flush: redirect flushes.

The counters are reset to 0 by i_rst_n, increment once per qualifying cycle and wrap modulo 2^CNT_W. When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - the opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
  - NOP_INSTR = 32'h00000013;
  - the enum hz_state_e {RUN, LU_BUBBLE, MEM_WAIT}.
- One sub-module, hazard_detect: purely combinational decode producing load_use.
- hazard_ctrl holds the FSM, counter and outputs.

Test Plan:
1. EX = lw x5,0(x1) (rd_wren = 1), ID = add x6,x5,x2 -> one cycle with o_pc_en = 0, o_ifid_en = 0, o_idex_flush = 1, o_state = 1. The next cycle is all enables = 1, o_state = 0.
2. EX = lw x0,..., ID = add x6,x0,x2; also ID = lui x5 with EX = lw x5 -> no stall in either case.
3. i_dmem_req_MEM = 1, i_dmem_ready low for 3 cycles then high -> 3 cycles of enables = 0 with o_memwb_bubble = 1. The ready cycle has normal outputs; o_mem_err is never set.
4. MEM_TIMEOUT = 4, ready never asserted -> o_mem_err pulses exactly once, on the 5th stall cycle, and the FSM returns to RUN.
5. i_redirect_EX and load-use in the same cycle -> o_ifid_flush = o_idex_flush = 1, o_pc_en = 1, no LU_BUBBLE. Redirect together with a memory wait -> stall only; the flush fires in the cycle after release.
6. i_rst_n asserted during MEM_WAIT at cycle 2 -> outputs return to reset values immediately and o_state = 0. With HAZARD_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard scheduler.
//   - RV32I major-opcode constants (instr[6:2])
//   - NOP_INSTR: canonical NOP (addi x0,x0,0) loaded by flushed stages
//   - hz_state_e: scheduler FSM encoding (RUN / LU_BUBBLE / MEM_WAIT)
package hazard_pkg;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_BUBBLE = 2'd1,
      MEM_WAIT  = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: purely combinational load-use detector.
// Ports:
//   instr_id   in  32  instruction in ID
//   instr_ex   in  32  instruction in EX
//   rd_wren_ex in  1   EX instruction writes rd
//   load_use   out 1   ID reads a register that the EX load has not produced yet
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [31:0] instr_id,
   input  logic [31:0] instr_ex,
   input  logic        rd_wren_ex,
   output logic        load_use
);

   logic [4:0] op_id_s;
   logic [4:0] op_ex_s;
   logic [4:0] rs1_id_s;
   logic [4:0] rs2_id_s;
   logic [4:0] rd_ex_s;
   logic       rs1_used_s;
   logic       rs2_used_s;
   logic       unused_bits_s;

   assign op_id_s  = instr_id[6:2];
   assign op_ex_s  = instr_ex[6:2];
   assign rs1_id_s = instr_id[19:15];
   assign rs2_id_s = instr_id[24:20];
   assign rd_ex_s  = instr_ex[11:7];

   // Only the register/opcode fields take part in the decision.
   assign unused_bits_s = ^{instr_id[31:25], instr_id[14:12], instr_id[1:0],
                            instr_ex[31:12], instr_ex[1:0]};

   // U-type and JAL carry immediate bits in the rs1 field; only R/S/B read rs2.
   assign rs1_used_s = (op_id_s != OP_LUI) && (op_id_s != OP_AUIPC) && (op_id_s != OP_JAL);
   assign rs2_used_s = (op_id_s == OP_OP) || (op_id_s == OP_STORE) || (op_id_s == OP_BRANCH);

   // x0 is never a real dependency, so rd == 0 cannot stall.
   assign load_use = (op_ex_s == OP_LOAD) && rd_wren_ex && (rd_ex_s != 5'd0) &&
                     ((rs1_used_s && (rs1_id_s == rd_ex_s)) ||
                      (rs2_used_s && (rs2_id_s == rd_ex_s)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall scheduler for the 5-stage RV32I core.
// Sequences load-use bubbles, data-memory wait stalls (with timeout) and
// redirect flushes onto the pipeline register enables/flushes.
// Ports:
//   i_clk, i_rst_n          clock (rising), asynchronous active-low reset
//   i_instr_ID/i_instr_EX   instructions in ID and EX
//   i_rd_wren_EX            EX instruction writes rd
//   i_redirect_EX           EX resolved a taken branch/jump
//   i_dmem_req_MEM          MEM stage has a valid data access
//   i_dmem_ready            data memory completes this cycle
//   o_pc_en, o_ifid_en, o_idex_en, o_exmem_en   register enables
//   o_ifid_flush, o_idex_flush, o_memwb_bubble  NOP insertion controls
//   o_mem_err               one-cycle pulse when a memory wait times out
//   o_state                 FSM state (debug)
// Optional build macro HAZARD_PERF_CNT_EN adds o_cnt_lu, o_cnt_memwait and
// o_cnt_flush (CNT_W-bit wrapping event counters).
// Outputs are combinational from state and inputs so that a memory wait
// freezes the pipeline in the same cycle it appears.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_instr_ID,
   input  logic [31:0]      i_instr_EX,
   input  logic             i_rd_wren_EX,
   input  logic             i_redirect_EX,
   input  logic             i_dmem_req_MEM,
   input  logic             i_dmem_ready,
   output logic             o_pc_en,
   output logic             o_ifid_en,
   output logic             o_ifid_flush,
   output logic             o_idex_en,
   output logic             o_idex_flush,
   output logic             o_exmem_en,
   output logic             o_memwb_bubble,
   output logic             o_mem_err,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0] o_cnt_lu,
   output logic [CNT_W-1:0] o_cnt_memwait,
   output logic [CNT_W-1:0] o_cnt_flush,
`endif
   output logic [1:0]       o_state
);

   localparam int              CW       = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   CNT_MAX  = CW'(MEM_TIMEOUT);

   hz_state_e       state_r;
   hz_state_e       state_nxt_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_nxt_s;
   logic            load_use_s;
   logic            mem_wait_s;
   logic            lu_take_s;
   logic            flush_take_s;

   hazard_detect u_detect (
      .instr_id   (i_instr_ID),
      .instr_ex   (i_instr_EX),
      .rd_wren_ex (i_rd_wren_EX),
      .load_use   (load_use_s)
   );

   assign mem_wait_s = i_dmem_req_MEM && !i_dmem_ready;
   assign o_state    = state_r;

   // State and wait-counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= RUN;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state, counter and pipeline control decode.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      o_pc_en        = 1'b1;
      o_ifid_en      = 1'b1;
      o_ifid_flush   = 1'b0;
      o_idex_en      = 1'b1;
      o_idex_flush   = 1'b0;
      o_exmem_en     = 1'b1;
      o_memwb_bubble = 1'b0;
      o_mem_err      = 1'b0;
      lu_take_s      = 1'b0;
      flush_take_s   = 1'b0;

      case (state_r)
         RUN: begin
            if (mem_wait_s) begin
               state_nxt_s = MEM_WAIT;
               cnt_nxt_s   = CNT_ONE;
            end else if (i_redirect_EX) begin
               flush_take_s = 1'b1;
            end else if (load_use_s) begin
               lu_take_s   = 1'b1;
               state_nxt_s = LU_BUBBLE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         // The load has moved on to MEM; forwarding now covers the dependency.
         LU_BUBBLE: begin
            if (mem_wait_s) begin
               state_nxt_s = MEM_WAIT;
               cnt_nxt_s   = CNT_ONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_wait_s && (cnt_r != CNT_MAX)) begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
               // Release cycle: EX was frozen, so redirect/load-use are
               // evaluated now. On timeout the MEM result is dropped.
               state_nxt_s = RUN;
               cnt_nxt_s   = {CW{1'b0}};
               if (mem_wait_s) begin
                  o_mem_err = 1'b1;
               end else begin
                  o_mem_err = 1'b0;
               end
               if (i_redirect_EX) begin
                  flush_take_s = 1'b1;
               end else if (load_use_s) begin
                  lu_take_s = 1'b1;
               end else begin
                  flush_take_s = 1'b0;
               end
            end
         end
         default: begin
            state_nxt_s = RUN;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase

      // Any cycle that keeps or enters MEM_WAIT freezes the whole pipeline.
      if (state_nxt_s == MEM_WAIT) begin
         o_pc_en        = 1'b0;
         o_ifid_en      = 1'b0;
         o_idex_en      = 1'b0;
         o_exmem_en     = 1'b0;
         o_memwb_bubble = 1'b1;
      end else if (o_mem_err) begin
         o_memwb_bubble = 1'b1;
      end else begin
         o_memwb_bubble = 1'b0;
      end

      if (flush_take_s) begin
         o_ifid_flush = 1'b1;
         o_idex_flush = 1'b1;
      end else if (lu_take_s) begin
         o_pc_en      = 1'b0;
         o_ifid_en    = 1'b0;
         o_idex_flush = 1'b1;
      end else begin
         o_ifid_flush = 1'b0;
      end

      // Reset overrides whatever the inputs are doing.
      if (!i_rst_n) begin
         o_pc_en        = 1'b1;
         o_ifid_en      = 1'b1;
         o_ifid_flush   = 1'b0;
         o_idex_en      = 1'b1;
         o_idex_flush   = 1'b0;
         o_exmem_en     = 1'b1;
         o_memwb_bubble = 1'b0;
         o_mem_err      = 1'b0;
         lu_take_s      = 1'b0;
         flush_take_s   = 1'b0;
      end else begin
         o_mem_err = o_mem_err;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_lu_r;
   logic [CNT_W-1:0] cnt_memwait_r;
   logic [CNT_W-1:0] cnt_flush_r;

   // Wrapping event counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_lu_r      <= {CNT_W{1'b0}};
         cnt_memwait_r <= {CNT_W{1'b0}};
         cnt_flush_r   <= {CNT_W{1'b0}};
      end else begin
         if (lu_take_s) begin
            cnt_lu_r <= cnt_lu_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (state_r == MEM_WAIT) begin
            cnt_memwait_r <= cnt_memwait_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (flush_take_s) begin
            cnt_flush_r <= cnt_flush_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign o_cnt_lu      = cnt_lu_r;
   assign o_cnt_memwait = cnt_memwait_r;
   assign o_cnt_flush   = cnt_flush_r;
`else
   logic [CNT_W-1:0] unused_cnt_w_s;
   assign unused_cnt_w_s = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven self-checking bench for hazard_ctrl
// (MEM_TIMEOUT = 4). Each table row is one clock cycle; the expected output
// vector is queued when the row is driven and popped when outputs are sampled.
module tb_hazard_ctrl;

   localparam logic [31:0] NOP     = 32'h00000013;
   localparam logic [31:0] LW_X5   = 32'h0000A283; // lw  x5,0(x1)
   localparam logic [31:0] LW_X0   = 32'h0000A003; // lw  x0,0(x1)
   localparam logic [31:0] ADD_X5  = 32'h00228333; // add x6,x5,x2
   localparam logic [31:0] ADD_X0  = 32'h00200333; // add x6,x0,x2
   localparam logic [31:0] LUI_X5  = 32'h000282B7; // lui x5,0x28 (rs1 field = 5)
   localparam logic [31:0] SW_X5   = 32'h0050A023; // sw  x5,0(x1)

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_err}
   localparam logic [7:0] O_N  = 8'b1101_0100;
   localparam logic [7:0] O_LU = 8'b0001_1100;
   localparam logic [7:0] O_ST = 8'b0000_0010;
   localparam logic [7:0] O_RD = 8'b1111_1100;
   localparam logic [7:0] O_TO = 8'b1101_0111;

   typedef struct {
      logic [31:0] id;
      logic [31:0] ex;
      logic        wren;
      logic        redir;
      logic        req;
      logic        rdy;
      logic [7:0]  out;
      logic [1:0]  st;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr_id = NOP;
   logic [31:0] instr_ex = NOP;
   logic        rd_wren = 1'b0;
   logic        redirect = 1'b0;
   logic        req = 1'b0;
   logic        rdy = 1'b0;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
   logic        memwb_bubble, mem_err;
   logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] cnt_lu, cnt_memwait, cnt_flush;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [9:0]  exp_q[$];
   vec_t        tbl[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_instr_ID     (instr_id),
      .i_instr_EX     (instr_ex),
      .i_rd_wren_EX   (rd_wren),
      .i_redirect_EX  (redirect),
      .i_dmem_req_MEM (req),
      .i_dmem_ready   (rdy),
      .o_pc_en        (pc_en),
      .o_ifid_en      (ifid_en),
      .o_ifid_flush   (ifid_flush),
      .o_idex_en      (idex_en),
      .o_idex_flush   (idex_flush),
      .o_exmem_en     (exmem_en),
      .o_memwb_bubble (memwb_bubble),
      .o_mem_err      (mem_err),
`ifdef HAZARD_PERF_CNT_EN
      .o_cnt_lu       (cnt_lu),
      .o_cnt_memwait  (cnt_memwait),
      .o_cnt_flush    (cnt_flush),
`endif
      .o_state        (state)
   );

   function automatic vec_t mk(input logic [31:0] id, input logic [31:0] ex,
                               input logic wren, input logic redir,
                               input logic rq, input logic rd,
                               input logic [7:0] out, input logic [1:0] st);
      vec_t v;
      v.id = id; v.ex = ex; v.wren = wren; v.redir = redir;
      v.req = rq; v.rdy = rd; v.out = out; v.st = st;
      return v;
   endfunction

   task automatic check(input string name);
      logic [9:0] got;
      logic [9:0] exp;
      got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_bubble, mem_err, state};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got outs=%b state=%0d, expected outs=%b state=%0d",
                  name, got[9:2], got[1:0], exp[9:2], exp[1:0]);
      end
   endtask

   // Called just after a falling edge; leaves at the next falling edge.
   task automatic apply(input vec_t v, input string name);
      instr_id = v.id; instr_ex = v.ex; rd_wren = v.wren;
      redirect = v.redir; req = v.req; rdy = v.rdy;
      exp_q.push_back({v.out, v.st});
      #2;
      check(name);
      @(negedge clk);
   endtask

   initial begin
      // Load-use via rs1, then the single bubble cycle with the condition still visible
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      tbl.push_back(mk(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, 2'd0));
      tbl.push_back(mk(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, O_N,  2'd1));
      tbl.push_back(mk(ADD_X5, NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // No stall: rd = x0, lui does not read rs1, load without rd write
      tbl.push_back(mk(ADD_X0, LW_X0, 1'b1, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      tbl.push_back(mk(LUI_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      tbl.push_back(mk(ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // Load-use via rs2 of a store
      tbl.push_back(mk(SW_X5,  LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, 2'd0));
      tbl.push_back(mk(SW_X5,  LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, O_N,  2'd1));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // Memory wait: 3 stall cycles, ready cycle is normal
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd0));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b1, O_N,  2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // Timeout (MEM_TIMEOUT = 4): error on the 5th stall cycle
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd0));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_TO, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // Redirect beats load-use; no bubble state follows
      tbl.push_back(mk(ADD_X5, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0, O_RD, 2'd0));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // Redirect under memory wait: stall only, flush in the release cycle
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b1, 1'b1, 1'b0, O_ST, 2'd0));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b1, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b1, 1'b1, 1'b1, O_RD, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));
      // Memory wait arriving in LU_BUBBLE; request drop counts as completion
      tbl.push_back(mk(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, 2'd0));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd1));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd2));
      tbl.push_back(mk(NOP,    NOP,   1'b0, 1'b0, 1'b0, 1'b0, O_N,  2'd0));

      // Reset values while a memory wait is presented on the inputs
      req = 1'b1; rdy = 1'b0;
      exp_q.push_back({O_N, 2'd0});
      #2;
      check("reset_outputs");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end

      // Reset asserted in the second MEM_WAIT cycle
      apply(mk(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd0), "mid_rst_stall0");
      apply(mk(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, O_ST, 2'd2), "mid_rst_stall1");
      rst_n = 1'b0;
      exp_q.push_back({O_N, 2'd0});
      #1;
      check("mid_rst_outputs");
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if ({cnt_lu, cnt_memwait, cnt_flush} !== 96'd0) begin
         n_fail++;
         $display("FAIL perf_cnt_reset: got %0d/%0d/%0d, expected 0/0/0",
                  cnt_lu, cnt_memwait, cnt_flush);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, O_N, 2'd0), "post_rst_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
